// File: rtl/transpose_buffer8.sv
// 8x8 transpose buffer between the row and column DCT passes.
// Rows are rounded and saturated on entry; two ping-pong banks let one block fill while the other drains.
module transpose_buffer8 #(
    parameter int WIDTH_I = 19,
    parameter int WIDTH_O = 16,
    parameter int SHIFT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH_I-1:0] d0,
    input  logic signed [WIDTH_I-1:0] d1,
    input  logic signed [WIDTH_I-1:0] d2,
    input  logic signed [WIDTH_I-1:0] d3,
    input  logic signed [WIDTH_I-1:0] d4,
    input  logic signed [WIDTH_I-1:0] d5,
    input  logic signed [WIDTH_I-1:0] d6,
    input  logic signed [WIDTH_I-1:0] d7,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH_O-1:0] q0,
    output logic signed [WIDTH_O-1:0] q1,
    output logic signed [WIDTH_O-1:0] q2,
    output logic signed [WIDTH_O-1:0] q3,
    output logic signed [WIDTH_O-1:0] q4,
    output logic signed [WIDTH_O-1:0] q5,
    output logic signed [WIDTH_O-1:0] q6,
    output logic signed [WIDTH_O-1:0] q7,
    output logic                      out_last
);

    localparam int RND_I     = 1 << (SHIFT - 1);
    localparam int SAT_MAX_I = (1 << (WIDTH_O - 1)) - 1;
    localparam logic signed [WIDTH_I:0] RND     = (WIDTH_I + 1)'(RND_I);
    localparam logic signed [WIDTH_I:0] SAT_MAX = (WIDTH_I + 1)'(SAT_MAX_I);
    localparam logic signed [WIDTH_I:0] SAT_MIN = ~SAT_MAX;

    // One extra bit of headroom so the rounding offset cannot wrap the largest input.
    function automatic logic signed [WIDTH_O-1:0] f_round_sat(input logic signed [WIDTH_I-1:0] din);
        logic signed [WIDTH_I:0] v_ext;
        logic signed [WIDTH_I:0] v_sh;
        v_ext = $signed({din[WIDTH_I-1], din}) + RND;
        v_sh  = v_ext >>> SHIFT;
        if (v_sh > SAT_MAX) begin
            return SAT_MAX[WIDTH_O-1:0];
        end else if (v_sh < SAT_MIN) begin
            return SAT_MIN[WIDTH_O-1:0];
        end
        return v_sh[WIDTH_O-1:0];
    endfunction

    logic signed [WIDTH_O-1:0] r_bank [2][8][8];
    logic [1:0]                r_full;
    logic                      r_wr_sel;
    logic                      r_rd_sel;
    logic [2:0]                r_row_cnt;
    logic [2:0]                r_col_cnt;

    logic signed [WIDTH_I-1:0] w_d   [8];
    logic signed [WIDTH_O-1:0] w_rnd [8];
    logic signed [WIDTH_O-1:0] w_q   [8];
    logic                      w_wr_fire;
    logic                      w_rd_fire;

    assign w_d[0] = d0;
    assign w_d[1] = d1;
    assign w_d[2] = d2;
    assign w_d[3] = d3;
    assign w_d[4] = d4;
    assign w_d[5] = d5;
    assign w_d[6] = d6;
    assign w_d[7] = d7;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_rnd[k] = f_round_sat(w_d[k]);
        end
    end

    assign in_ready  = !r_full[r_wr_sel];
    assign out_valid = r_full[r_rd_sel];
    assign out_last  = out_valid && (r_col_cnt == 3'd7);
    assign w_wr_fire = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;

    // Column read: row k of the read bank at the current column; zeroed while nothing is valid.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_q[k] = out_valid ? r_bank[r_rd_sel][k][r_col_cnt] : '0;
        end
    end

    assign q0 = w_q[0];
    assign q1 = w_q[1];
    assign q2 = w_q[2];
    assign q3 = w_q[3];
    assign q4 = w_q[4];
    assign q5 = w_q[5];
    assign q6 = w_q[6];
    assign q7 = w_q[7];

    // A bank is never written while full, so a set and a clear never target the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full    <= 2'b00;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_row_cnt <= 3'd0;
            r_col_cnt <= 3'd0;
        end else begin
            if (w_wr_fire) begin
                r_row_cnt <= r_row_cnt + 3'd1;
                if (r_row_cnt == 3'd7) begin
                    r_full[r_wr_sel] <= 1'b1;
                    r_wr_sel         <= ~r_wr_sel;
                end
            end
            if (w_rd_fire) begin
                r_col_cnt <= r_col_cnt + 3'd1;
                if (r_col_cnt == 3'd7) begin
                    r_full[r_rd_sel] <= 1'b0;
                    r_rd_sel         <= ~r_rd_sel;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire && !rst) begin
            for (int k = 0; k < 8; k++) begin
                r_bank[r_wr_sel][r_row_cnt][k] <= w_rnd[k];
            end
        end
    end

endmodule

// File: doc/transpose_buffer8.md
Name: transpose_buffer8

Overview:
- Transposition stage directly downstream of the 8-point 1-D row DCT. Collects 8 rows of 8 first-pass coefficients, each a y0..y7 output vector.
- Rounds and right-shifts each coefficient by the HEVC first-stage shift, then saturates it. Delivers the 8x8 block column by column to the second-pass (column) 8-point DCT.
- Ping-pong double buffering: one block is written while the previous block is read, so sustained throughput is one row in and one column out per cycle.

Parameters:
- WIDTH_I, 19, signed width of each input coefficient (matches row DCT WIDTH_Y).
- WIDTH_O, 16, signed width of each stored/output coefficient (second-pass WIDTH_X).
- SHIFT, 2, first-stage right shift, with rounding; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  row present on d0..d7.
- in_ready  out  1  buffer can accept a row this cycle.
- d0..d7  in  WIDTH_I each  signed row coefficients, index = column position.
- out_valid  out  1  column present on q0..q7.
- out_ready  in  1  downstream accepts the column this cycle.
- q0..q7  out  WIDTH_O each  signed column coefficients, index = row position.
- out_last  out  1  high with the 8th column (col 7) of a block.

Behaviour:
- Storage: two banks (0, 1), each 8x8 x WIDTH_O registers.
- Per-bank full flag.
- Pointers: wr_sel, rd_sel (1 bit each), row_cnt and col_cnt (3 bits each).
- Reset (rst=1 at an edge):
  - full=00, wr_sel=rd_sel=0, row_cnt=col_cnt=0.
  - Outputs: in_ready=1, out_valid=0, out_last=0, q0..q7=0.
  - Bank contents are not cleared.
  - Reset mid-block discards any partial or full block, and any pending input row is dropped.
- in_ready = !full[wr_sel] (combinational).
- A row is accepted when in_valid && in_ready.
- Write, on an accepted row:
  - Each dk is stored, after rounding, at bank[wr_sel][row_cnt][k].
  - row_cnt increments.
  - When row_cnt==7: set full[wr_sel], toggle wr_sel, and row_cnt wraps to 0.
- Rounding: v = (d + 2^(SHIFT-1)) >>> SHIFT, arithmetic, computed at WIDTH_I+1 bits. Then saturate to [-2^(WIDTH_O-1), 2^(WIDTH_O-1)-1].
- Read:
  - out_valid = full[rd_sel].
  - qk = bank[rd_sel][k][col_cnt], a combinational mux.
  - out_last = out_valid && col_cnt==7.
- Column transfer when out_valid && out_ready:
  - col_cnt increments.
  - When col_cnt==7: clear full[rd_sel], toggle rd_sel, and col_cnt wraps to 0.
- q0..q7 are 0 when out_valid=0 (forced by the mux).
- Latency: if the 8th row is accepted at edge N, out_valid=1 and column 0 is presented in the cycle after edge N.
- Backpressure: with out_ready=0, q and col_cnt hold. Writing continues into the other bank; once both banks are full, in_ready=0 until the read bank drains.
- Simultaneous events, same edge: final column of bank A read and final row of bank B written.
  - A is cleared and B is set.
  - wr_sel moves to A, so in_ready=1 in the next cycle.
  - rd_sel moves to B, so out_valid=1 with no bubble.
- Set/clear of the same bank at the same edge cannot occur, because a bank is never written while full.
- in_valid while in_ready=0: no state change, and the row is not captured.

Test Plan:
- Reset then idle: after rst, in_ready=1, out_valid=0, q0..q7=0. Hold for 10 cycles with in_valid=0, and all outputs stay unchanged.
- Single block transpose:
  - Stimulus: row r, dk = 4*(8r+k); out_ready=1.
  - Cycle after 8th row: column 0 with qk = 8k.
  - Subsequent columns c give qk = 8k+c.
  - out_last only on c=7.
  - out_valid falls after 8 columns.
- Rounding and saturation, using SHIFT=2, WIDTH_O=16:
  - 6 → 2; 5 → 1; -6 → -1; -7 → -2.
  - 262143 → 32767; -262144 → -32768.
- Continuous streaming: 4 back-to-back blocks with in_valid and out_ready held high.
  - in_ready never drops.
  - out_valid is continuous from cycle 9 for 32 cycles.
  - Every column matches a golden transpose.
- Backpressure: out_ready=0 while 16 rows are offered.
  - in_ready=0 after the 16th accepted row, and the 17th row is held off.
  - q holds column 0 of block 0.
  - Releasing out_ready drains block 0, then block 1, with correct data.
- Reset mid-operation: assert rst after 5 rows of block 1 while block 0 is being read at column 3.
  - Next cycle: out_valid=0, in_ready=1.
  - A fresh block afterwards transposes correctly, with no stale data.
